// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: reads NUM_OF_WORDS words from memory, appends padding, streams 512-bit blocks.
// Optional: define SHA256_PAD_BSWAP_EN to byte-reverse memory-sourced words (little-endian storage).
module sha256_msg_padder #(
    parameter int NUM_OF_WORDS = 20,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] message_addr,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_read_data,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic [511:0]      blk_data,
    output logic [7:0]        blk_index,
    output logic              blk_last,
    output logic              busy,
    output logic              done
);
    localparam int          NB        = (NUM_OF_WORDS + 18) / 16;
    localparam logic [15:0] MSG_WORDS = 16'(NUM_OF_WORDS);
    localparam logic [15:0] LEN_G     = 16'(16 * NB - 1);
    localparam logic [31:0] LEN_BITS  = 32'(NUM_OF_WORDS * 32);
    localparam logic [7:0]  LAST_BLK  = 8'(NB - 1);

    typedef enum logic [1:0] {IDLE, FILL, PRESENT, FIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] base;
    logic [7:0]        blk_cnt;
    logic [4:0]        slot;
    logic [15:0]       g_cap;
    logic [15:0]       g_issue;
    logic [15:0]       g_first;
    logic [31:0]       mem_word;
    logic [31:0]       cap_word;

    assign mem_clk   = clk;
    assign mem_we    = 1'b0;
    assign blk_index = blk_cnt;
    assign blk_last  = (state == PRESENT) && (blk_cnt == LAST_BLK);

    // slot k presents address of word k; capture in slot k writes word k-1
    assign g_cap   = {4'b0, blk_cnt, 4'b0} + {11'b0, slot} - 16'd1;
    assign g_issue = {4'b0, blk_cnt, 4'b0} + {11'b0, slot} + 16'd1;
    assign g_first = {4'b0, blk_cnt + 8'd1, 4'b0};

`ifdef SHA256_PAD_BSWAP_EN
    assign mem_word = {mem_read_data[7:0], mem_read_data[15:8],
                       mem_read_data[23:16], mem_read_data[31:24]};
`else
    assign mem_word = mem_read_data;
`endif

    always_comb begin
        if (g_cap < MSG_WORDS)
            cap_word = mem_word;
        else if (g_cap == MSG_WORDS)
            cap_word = 32'h8000_0000;
        else if (g_cap == LEN_G)
            cap_word = LEN_BITS;
        else
            cap_word = '0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        blk_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = FILL;
            end
            FILL: begin
                busy = 1'b1;
                if (slot == 5'd16)
                    state_nxt = PRESENT;
            end
            PRESENT: begin
                busy      = 1'b1;
                blk_valid = 1'b1;
                if (blk_ready)
                    state_nxt = (blk_cnt == LAST_BLK) ? FIN : FILL;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base     <= '0;
            blk_cnt  <= '0;
            slot     <= '0;
            blk_data <= '0;
            mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base     <= message_addr;
                        blk_cnt  <= '0;
                        slot     <= '0;
                        mem_addr <= message_addr;
                    end
                end
                FILL: begin
                    slot <= (slot == 5'd16) ? 5'd0 : slot + 5'd1;
                    if (slot != 5'd0)
                        blk_data <= {blk_data[479:0], cap_word};
                    // address register is only advanced for message words, so each is read once
                    if (slot < 5'd15 && g_issue < MSG_WORDS)
                        mem_addr <= base + ADDR_W'(g_issue);
                end
                PRESENT: begin
                    if (blk_ready && blk_cnt != LAST_BLK) begin
                        blk_cnt <= blk_cnt + 8'd1;
                        if (g_first < MSG_WORDS)
                            mem_addr <= base + ADDR_W'(g_first);
                    end
                end
                FIN: blk_cnt <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: three instances (20, 13, 14 words) checked against a padding model.
module tb_sha256_msg_padder;
    localparam int NW [3] = '{20, 13, 14};

    logic         clk = 1'b0;
    logic         reset;
    logic         start_s [3];
    logic [15:0]  addr_s  [3];
    logic         ready_s [3];
    logic         mclk_s  [3];
    logic         we_s    [3];
    logic [15:0]  maddr_s [3];
    logic [31:0]  rd_s    [3];
    logic         valid_s [3];
    logic [511:0] data_s  [3];
    logic [7:0]   idx_s   [3];
    logic         last_s  [3];
    logic         busy_s  [3];
    logic         done_s  [3];

    logic [31:0]  mem [0:65535];
    bit           seen [int];
    int           cur_dut = 0;
    int           checks = 0;
    int           passed = 0;
    int           fails  = 0;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        sha256_msg_padder #(.NUM_OF_WORDS(NW[i]), .ADDR_W(16)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .start        (start_s[i]),
            .message_addr (addr_s[i]),
            .mem_clk      (mclk_s[i]),
            .mem_we       (we_s[i]),
            .mem_addr     (maddr_s[i]),
            .mem_read_data(rd_s[i]),
            .blk_valid    (valid_s[i]),
            .blk_ready    (ready_s[i]),
            .blk_data     (data_s[i]),
            .blk_index    (idx_s[i]),
            .blk_last     (last_s[i]),
            .busy         (busy_s[i]),
            .done         (done_s[i])
        );
    end

    initial forever #5 clk = ~clk;

    always @(posedge clk)
        for (int i = 0; i < 3; i++) rd_s[i] <= mem[maddr_s[i]];

    always @(negedge clk)
        if (busy_s[cur_dut]) seen[int'(maddr_s[cur_dut])] = 1'b1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected run completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int n, input logic [15:0] base, input int g);
        int nb = (n + 18) / 16;
        logic [31:0] w;
        if (g < n) begin
            w = mem[16'(int'(base) + g)];
`ifdef SHA256_PAD_BSWAP_EN
            w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
            return w;
        end
        if (g == n) return 32'h8000_0000;
        if (g == 16 * nb - 1) return 32'(n * 32);
        return 32'h0;
    endfunction

    function automatic logic [511:0] ref_block(input int n, input logic [15:0] base, input int b);
        logic [511:0] r;
        for (int j = 0; j < 16; j++) r[511-32*j -: 32] = ref_word(n, base, 16 * b + j);
        return r;
    endfunction

    task automatic chk_reset(input int d);
        chk("rst_valid", valid_s[d], 0);
        chk("rst_busy", busy_s[d], 0);
        chk("rst_done", done_s[d], 0);
        chk("rst_data", data_s[d], 0);
        chk("rst_index", idx_s[d], 0);
        chk("rst_last", last_s[d], 0);
        chk("rst_mem_addr", maddr_s[d], 0);
        chk("rst_mem_we", we_s[d], 0);
        chk("mem_clk", mclk_s[d], clk);
    endtask

    // mode: 0 ready always, 1 random ready, 2 hold ready low 10 cycles on block 0
    task automatic run(input int d, input logic [15:0] base, input int mode,
                       input bit dbl, input bit abort);
        int n = NW[d];
        int nb = (n + 18) / 16;
        int lat, hold, bad, extra;
        logic rdy;
        logic [15:0] held;
        logic [511:0] exp_blk;
        cur_dut = d;
        seen.delete();
        @(negedge clk);
        start_s[d] = 1'b1;
        addr_s[d]  = base;
        @(negedge clk);
        start_s[d] = 1'b0;
        for (int b = 0; b < nb; b++) begin
            lat = 0;
            while (!valid_s[d] && lat < 40) begin
                if (abort && b == 1 && lat == 6) begin
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    ready_s[d] = 1'b0;
                    chk_reset(d);
                    @(negedge clk);
                    chk("rst_idle_busy", busy_s[d], 0);
                    chk("rst_idle_valid", valid_s[d], 0);
                    return;
                end
                start_s[d] = dbl && b == 0 && lat == 4;
                if (start_s[d]) addr_s[d] = base + 16'h0300;
                ready_s[d] = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
                lat++;
            end
            start_s[d] = 1'b0;
            chk("latency", lat, 17);
            exp_blk = ref_block(n, base, b);
            held = maddr_s[d];
            hold = 0;
            while (1) begin
                case (mode)
                    1:       rdy = 1'($urandom_range(0, 1)) || hold >= 20;
                    2:       rdy = (b != 0) || hold >= 10;
                    default: rdy = 1'b1;
                endcase
                ready_s[d] = rdy;
                chk("blk_valid", valid_s[d], 1);
                chk("blk_data", data_s[d], exp_blk);
                chk("blk_index", idx_s[d], 8'(b));
                chk("blk_last", last_s[d], b == nb - 1);
                if (mode == 2 && b == 0) chk("hold_mem_addr", maddr_s[d], held);
                if (rdy) break;
                hold++;
                @(negedge clk);
            end
            @(negedge clk);
            ready_s[d] = 1'b0;
            chk("valid_drop", valid_s[d], 0);
            chk("done_pulse", done_s[d], b == nb - 1);
            chk("busy_after_xfer", busy_s[d], b != nb - 1);
        end
        @(negedge clk);
        chk("done_single", done_s[d], 0);
        extra = 0;
        repeat (25) begin
            if (valid_s[d] || busy_s[d] || done_s[d]) extra++;
            @(negedge clk);
        end
        chk("no_second_run", extra, 0);
        chk("read_count", seen.num(), n);
        bad = 0;
        foreach (seen[a]) if (int'(16'(a - int'(base))) >= n) bad++;
        chk("read_range", bad, 0);
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            addr_s[d]  = '0;
            ready_s[d] = 1'b0;
        end
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        for (int i = 0; i < 40; i++) mem[32'h100 + i] = 32'hA000_0000 + i;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) chk_reset(d);
        reset = 1'b0;

        run(0, 16'h0100, 0, 1'b0, 1'b0);
        run(1, 16'h0100, 0, 1'b0, 1'b0);
        run(2, 16'h0100, 0, 1'b0, 1'b0);
        run(0, 16'h0100, 2, 1'b0, 1'b0);
        run(0, 16'h0100, 0, 1'b0, 1'b1);
        run(0, 16'h0100, 0, 1'b0, 1'b0);
        run(0, 16'h0100, 0, 1'b1, 1'b0);
        run(2, 16'hFFF8, 1, 1'b1, 1'b0);
        for (int r = 0; r < 6; r++) run(r % 3, 16'($urandom), 1, r[0], 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
